// File: rtl/arb_burst_ctrl.sv
// Burst mover behind the 4-way round-robin arbiter.
// Latches the granted owner and streams its beats to a shared target.
module arb_burst_ctrl #(
  parameter int DW    = 8,
  parameter int LEN_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         grant,
  input  logic [4*DW-1:0]    req_data,
  input  logic [4*LEN_W-1:0] req_len,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  output logic [1:0]         out_src,
  output logic               out_last,
  input  logic               out_ready,
  output logic [3:0]         beat_ack,
  output logic [3:0]         done,
  output logic               busy,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DONE,
    S_GAP
  } state_t;

  state_t             state;
  logic [1:0]         owner;
  logic [LEN_W-1:0]   cnt;
  logic [1:0]         gsel;
  logic               gmulti;
  logic [LEN_W-1:0]   len_sel;
  logic [DW-1:0]      data_sel;
  logic               accept;

  // Lowest set grant bit wins; a multi-hot grant is flagged.
  always_comb begin
    gsel = 2'd0;
    priority case (1'b1)
      grant[0]: gsel = 2'd0;
      grant[1]: gsel = 2'd1;
      grant[2]: gsel = 2'd2;
      grant[3]: gsel = 2'd3;
      default:  gsel = 2'd0;
    endcase
    gmulti = (grant & (grant - 4'd1)) != 4'd0;
  end

  // Lane selects for the captured length and the owner's beat.
  always_comb begin
    len_sel  = req_len[int'(gsel)*LEN_W +: LEN_W];
    data_sel = req_data[int'(owner)*DW +: DW];
  end

  // Handshake decode and status back to the requesters.
  always_comb begin
    accept   = out_valid & out_ready;
    beat_ack = accept ? (4'b0001 << owner) : 4'b0000;
    busy     = state != S_IDLE;
  end

  // Burst sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      owner     <= 2'd0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 2'd0;
      out_last  <= 1'b0;
      done      <= 4'b0000;
      err       <= 1'b0;
    end else begin
      done <= 4'b0000;
      unique case (state)
        S_IDLE: begin
          if (grant != 4'b0000) begin
            owner <= gsel;
            cnt   <= len_sel;
            err   <= err | gmulti;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          out_data  <= data_sel;
          out_src   <= owner;
          out_last  <= cnt == '0;
          out_valid <= 1'b1;
          state     <= S_SEND;
        end
        S_SEND: begin
          if (accept) begin
            out_valid <= 1'b0;
            if (cnt != '0) begin
              cnt   <= cnt - 1'b1;
              state <= S_LOAD;
            end else begin
              done  <= 4'b0001 << owner;
              state <= S_DONE;
            end
          end
        end
        S_DONE: state <= S_GAP;
        S_GAP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_burst_ctrl.sv
// Randomized bench for arb_burst_ctrl.
// A timeline model of bursts predicts every output per cycle.
module tb_arb_burst_ctrl;

  localparam int DW = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [3:0]    grant = '0;
  logic [4*DW-1:0] req_data = '0;
  logic [4*LW-1:0] req_len = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_src;
  logic          out_last;
  logic          out_ready = 1'b0;
  logic [3:0]    beat_ack;
  logic [3:0]    done;
  logic          busy;
  logic          err;

  arb_burst_ctrl #(.DW(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .grant(grant),
    .req_data(req_data), .req_len(req_len),
    .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_last(out_last),
    .out_ready(out_ready), .beat_ack(beat_ack),
    .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // stimulus
  logic [3:0]    g_v = '0;
  logic          r_v = 1'b0;
  logic [LW-1:0] len_v [4];
  logic [DW-1:0] mem [4][16];

  // model: edge count and burst timeline
  int e = 0;
  bit m_act = 0;
  bit m_vld = 0;
  bit m_err = 0;
  int m_own = 0;
  int m_left = 0;
  int m_k = 0;
  int m_valid_at = 0;
  int m_free_at = 0;
  int m_done_at = -10;

  function automatic logic [3:0] oh(input int i);
    return 4'(1 << i);
  endfunction

  function automatic int lowest(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic apply();
    grant = g_v;
    out_ready = r_v;
    for (int i = 0; i < 4; i++) begin
      req_len[i*LW +: LW] = len_v[i];
      if (m_act && i == m_own)
        req_data[i*DW +: DW] = mem[i][m_k];
      else
        req_data[i*DW +: DW] = mem[i][0];
    end
  endtask

  task automatic model_edge();
    bit acc;
    bit capt;
    acc  = m_vld && r_v;
    capt = !m_act && (e > m_free_at) && (g_v != 4'b0000);
    if (acc) begin
      m_vld = 0;
      if (m_left == 0) begin
        m_act = 0;
        m_done_at = e;
        m_free_at = e + 2;
      end else begin
        m_left--;
        m_k++;
        m_valid_at = e + 1;
      end
    end else if (m_act && !m_vld && e == m_valid_at) begin
      m_vld = 1;
    end
    if (capt) begin
      m_own = lowest(g_v);
      m_left = int'(len_v[m_own]);
      m_k = 0;
      m_act = 1;
      m_valid_at = e + 1;
      if ((g_v & (g_v - 4'd1)) != 4'd0) m_err = 1;
    end
  endtask

  task automatic check_outs();
    chk("out_valid", out_valid, m_vld);
    if (m_vld) begin
      chk("out_data", out_data, mem[m_own][m_k]);
      chk("out_src", out_src, m_own);
      chk("out_last", out_last, m_left == 0);
    end
    chk("done", done, (e == m_done_at) ? oh(m_own) : 4'b0000);
    chk("busy", busy, m_act || e < m_free_at);
    chk("err", err, m_err);
  endtask

  task automatic cycle();
    apply();
    #1;
    chk("beat_ack", beat_ack, (m_vld && r_v) ? oh(m_own) : 4'b0000);
    @(posedge clk);
    e++;
    model_edge();
    @(negedge clk);
    check_outs();
  endtask

  task automatic reset_model();
    m_act = 0;
    m_vld = 0;
    m_err = 0;
    m_free_at = e;
    m_done_at = -10;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 4'b0000);
    chk("rst_err", err, 1'b0);
    chk("rst_data", out_data, 0);
    chk("rst_src", out_src, 0);
    chk("rst_last", out_last, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hold_valid", out_valid, 1'b0);
    chk("rst_hold_done", done, 4'b0000);
    rst = 1'b1;
    reset_model();
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 4; i++)
      if (!(m_act && i == m_own))
        for (int j = 0; j < 16; j++) mem[i][j] = 8'($urandom);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    g_v = 4'b0000;
    while ((m_act || e < m_free_at + 1) && n < 200) begin
      r_v = 1'b1;
      cycle();
      n++;
    end
    chk(tag, n < 200, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      len_v[i] = '0;
      for (int j = 0; j < 16; j++) mem[i][j] = 8'($urandom);
    end
    apply();
    @(negedge clk);
    do_reset();

    // one-beat burst from requester 0
    mem[0][0] = 8'hA5;
    len_v[0] = 4'd0;
    g_v = 4'b0001;
    r_v = 1'b1;
    cycle();
    g_v = 4'b0000;
    repeat (7) cycle();

    // four beats from requester 2 with ready toggling
    len_v[2] = 4'd3;
    g_v = 4'b0100;
    cycle();
    g_v = 4'b0000;
    for (int i = 0; i < 24; i++) begin
      r_v = i[0];
      len_v[2] = 4'($urandom);
      cycle();
    end
    wait_idle("t2_idle");

    // two owners queued back to back
    len_v[0] = 4'd2;
    len_v[3] = 4'd1;
    g_v = 4'b0001;
    cycle();
    g_v = 4'b1000;
    for (int i = 0; i < 20; i++) begin
      r_v = 1'b1;
      cycle();
    end
    wait_idle("t3_idle");

    // random one-hot traffic, grant noise while busy
    for (int c = 0; c < 1500; c++) begin
      int s;
      s = int'($urandom_range(0, 5));
      g_v = (s < 4) ? oh(s) : 4'b0000;
      r_v = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) len_v[i] = 4'($urandom);
      rand_mem();
      cycle();
    end
    wait_idle("rand_idle");

    // reset during the third beat
    begin
      int n;
      len_v[0] = 4'd5;
      g_v = 4'b0001;
      n = 0;
      while (!(m_act && m_vld && m_k == 2) && n < 200) begin
        r_v = ($urandom_range(0, 1) != 0);
        cycle();
        g_v = 4'b0000;
        n++;
      end
      chk("t5_reach", n < 200, 1'b1);
      do_reset();
      len_v[1] = 4'd3;
      g_v = 4'b0010;
      cycle();
      g_v = 4'b0000;
      for (int i = 0; i < 20; i++) begin
        r_v = 1'b1;
        cycle();
      end
      wait_idle("t5_idle");
    end

    // multi-hot grant raises sticky err
    len_v[1] = 4'd1;
    g_v = 4'b0110;
    cycle();
    g_v = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      r_v = 1'b1;
      cycle();
    end
    for (int c = 0; c < 300; c++) begin
      g_v = 4'($urandom);
      r_v = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < 4; i++) len_v[i] = 4'($urandom);
      rand_mem();
      cycle();
    end
    wait_idle("t4_idle");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
